voice_alloc: RTL and testbench

Polyphonic voice allocator that turns decoded MIDI note-on/note-off events into the four per-voice note number and velocity buses consumed by the NCO bank. It holds a 4-slot voice table with least-recently-allocated ranking. It retriggers held notes, fills free slots lowest-index first, and steals the oldest voice when all four are busy. It sits between the MIDI message decoder and the NCO bank.

---
 rtl/voice_alloc_if.sv | 33 +++
 rtl/voice_alloc.sv | 203 ++++++++++++++++++++
 tb/tb_voice_alloc.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_alloc_if.sv
// rtl/voice_alloc_if.sv - note event handshake between the MIDI decoder and the voice allocator
//
// Ports (signals carried by the interface):
//   EV_VALID  decoder -> allocator  event present
//   EV_READY  allocator -> decoder  event taken on the CLK edge where EV_VALID & EV_READY
//   EV_ON     decoder -> allocator  1 = note-on, 0 = note-off
//   EV_NOTE   decoder -> allocator  MIDI note number (7b)
//   EV_VEL    decoder -> allocator  MIDI velocity (7b)
// The master modport is the event source (decoder); the slave modport is the allocator.

interface voice_alloc_if;
    logic       EV_VALID;
    logic       EV_READY;
    logic       EV_ON;
    logic [6:0] EV_NOTE;
    logic [6:0] EV_VEL;

    modport master (
        output EV_VALID,
        output EV_ON,
        output EV_NOTE,
        output EV_VEL,
        input  EV_READY
    );

    modport slave (
        input  EV_VALID,
        input  EV_ON,
        input  EV_NOTE,
        input  EV_VEL,
        output EV_READY
    );
endinterface

// File: rtl/voice_alloc.sv
// rtl/voice_alloc.sv - 4-voice polyphonic allocator with least-recently-allocated stealing
//
// Ports:
//   CLK            system clock
//   RST_N          asynchronous active-low reset
//   CE             clock enable; FSM, table and ranks advance only when high
//   ALL_OFF        panic; silences all voices when serviced in IDLE
//   ev             event handshake (slave side of voice_alloc_if)
//   NOTE_NUM_0..3  per-voice note number to the NCO bank
//   NOTE_VEL_0..3  per-voice velocity to the NCO bank (0 = silent)
//   VOICE_ACTIVE   bit i set while voice i holds a sounding note
//
// Each event takes three CE-qualified edges: accept (IDLE), table lookup
// (MATCH) and table update (WRITE). The lookup results are registered so the
// update cycle only has to pick a slot and shift ranks.

module voice_alloc (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         CE,
    input  logic         ALL_OFF,
    voice_alloc_if.slave ev,
    output logic [6:0]   NOTE_NUM_0,
    output logic [6:0]   NOTE_NUM_1,
    output logic [6:0]   NOTE_NUM_2,
    output logic [6:0]   NOTE_NUM_3,
    output logic [6:0]   NOTE_VEL_0,
    output logic [6:0]   NOTE_VEL_1,
    output logic [6:0]   NOTE_VEL_2,
    output logic [6:0]   NOTE_VEL_3,
    output logic [3:0]   VOICE_ACTIVE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MATCH = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t      state_q;

    // Voice table. rank 0 = most recently allocated, 3 = oldest; the four
    // ranks always form a permutation of 0..3.
    logic [6:0]  note_q   [4];
    logic [6:0]  vel_q    [4];
    logic [1:0]  rank_q   [4];
    logic [3:0]  active_q;

    // Latched event. A note-on with zero velocity is folded into a note-off
    // at accept time so the later stages only see two kinds of event.
    logic        ev_on_q;
    logic [6:0]  ev_note_q;
    logic [6:0]  ev_vel_q;

    // Registered lookup results from MATCH.
    logic [3:0]  hit_q;
    logic        free_any_q;
    logic [1:0]  free_idx_q;
    logic [1:0]  old_idx_q;

    // Lookup combinational results.
    logic [3:0]  hit_c;
    logic        free_any_c;
    logic [1:0]  free_idx_c;
    logic [1:0]  old_idx_c;

    // Write-stage slot selection.
    logic        hit_any;
    logic [1:0]  hit_idx;
    logic [1:0]  target_c;
    logic [1:0]  tgt_rank_c;

    // Gating with RST_N keeps the handshake closed while reset is held,
    // even though the FSM itself already sits in IDLE.
    assign ev.EV_READY = RST_N & CE & ~ALL_OFF & (state_q == S_IDLE);

    always_comb begin
        hit_c      = '0;
        free_any_c = 1'b0;
        free_idx_c = 2'd0;
        old_idx_c  = 2'd0;
        // Scanning downward lets the lowest-index free slot win.
        for (int i = 3; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_any_c = 1'b1;
                free_idx_c = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            hit_c[i] = active_q[i] && (note_q[i] == ev_note_q);
            if (rank_q[i] == 2'd3) begin
                old_idx_c = 2'(i);
            end
        end
    end

    always_comb begin
        hit_any = |hit_q;
        hit_idx = 2'd0;
        // At most one slot can match since a held note always retriggers its
        // own slot; the priority order only matters for a corrupted table.
        for (int i = 3; i >= 0; i--) begin
            if (hit_q[i]) begin
                hit_idx = 2'(i);
            end
        end
        if (hit_any) begin
            target_c = hit_idx;
        end else if (free_any_q) begin
            target_c = free_idx_q;
        end else begin
            target_c = old_idx_q;
        end
        tgt_rank_c = rank_q[target_c];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            active_q   <= '0;
            ev_on_q    <= 1'b0;
            ev_note_q  <= '0;
            ev_vel_q   <= '0;
            hit_q      <= '0;
            free_any_q <= 1'b0;
            free_idx_q <= 2'd0;
            old_idx_q  <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                rank_q[i] <= 2'(i);
            end
        end else if (CE) begin
            case (state_q)
                S_IDLE: begin
                    if (ALL_OFF) begin
                        // Panic wins over a pending event; the event is not
                        // accepted and stays on the bus.
                        active_q <= '0;
                        for (int i = 0; i < 4; i++) begin
                            vel_q[i] <= '0;
                        end
                    end else if (ev.EV_VALID) begin
                        ev_on_q   <= ev.EV_ON && (ev.EV_VEL != 7'd0);
                        ev_note_q <= ev.EV_NOTE;
                        ev_vel_q  <= ev.EV_VEL;
                        state_q   <= S_MATCH;
                    end
                end

                S_MATCH: begin
                    hit_q      <= hit_c;
                    free_any_q <= free_any_c;
                    free_idx_q <= free_idx_c;
                    old_idx_q  <= old_idx_c;
                    state_q    <= S_WRITE;
                end

                S_WRITE: begin
                    if (ev_on_q) begin
                        // Move the target to the front of the age order:
                        // everything younger than it ages by one.
                        for (int i = 0; i < 4; i++) begin
                            if (2'(i) == target_c) begin
                                note_q[i]   <= ev_note_q;
                                vel_q[i]    <= ev_vel_q;
                                active_q[i] <= 1'b1;
                                rank_q[i]   <= 2'd0;
                            end else if (rank_q[i] < tgt_rank_c) begin
                                rank_q[i] <= rank_q[i] + 2'd1;
                            end
                        end
                    end else begin
                        // Note-off keeps the note number and age so the
                        // release tail stays on the same pitch.
                        for (int i = 0; i < 4; i++) begin
                            if (hit_q[i]) begin
                                vel_q[i]    <= '0;
                                active_q[i] <= 1'b0;
                            end
                        end
                    end
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign NOTE_NUM_0   = note_q[0];
    assign NOTE_NUM_1   = note_q[1];
    assign NOTE_NUM_2   = note_q[2];
    assign NOTE_NUM_3   = note_q[3];
    assign NOTE_VEL_0   = vel_q[0];
    assign NOTE_VEL_1   = vel_q[1];
    assign NOTE_VEL_2   = vel_q[2];
    assign NOTE_VEL_3   = vel_q[3];
    assign VOICE_ACTIVE = active_q;

endmodule

// File: tb/tb_voice_alloc.sv
// tb/tb_voice_alloc.sv - self-checking bench for voice_alloc

module tb_voice_alloc;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       CE;
    logic       ALL_OFF;
    logic [6:0] NOTE_NUM_0, NOTE_NUM_1, NOTE_NUM_2, NOTE_NUM_3;
    logic [6:0] NOTE_VEL_0, NOTE_VEL_1, NOTE_VEL_2, NOTE_VEL_3;
    logic [3:0] VOICE_ACTIVE;

    voice_alloc_if ev_if ();

    voice_alloc dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .CE           (CE),
        .ALL_OFF      (ALL_OFF),
        .ev           (ev_if),
        .NOTE_NUM_0   (NOTE_NUM_0),
        .NOTE_NUM_1   (NOTE_NUM_1),
        .NOTE_NUM_2   (NOTE_NUM_2),
        .NOTE_NUM_3   (NOTE_NUM_3),
        .NOTE_VEL_0   (NOTE_VEL_0),
        .NOTE_VEL_1   (NOTE_VEL_1),
        .NOTE_VEL_2   (NOTE_VEL_2),
        .NOTE_VEL_3   (NOTE_VEL_3),
        .VOICE_ACTIVE (VOICE_ACTIVE)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain arrays plus an age list of slot indices,
    // newest first. Allocation moves a slot to the front of the list.
    logic [6:0] m_note [4];
    logic [6:0] m_vel  [4];
    logic [3:0] m_act;
    int         age [$];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_note[i] = 7'd0;
            m_vel[i]  = 7'd0;
        end
        m_act = 4'd0;
        age = '{0, 1, 2, 3};
    endtask

    task automatic model_all_off();
        for (int i = 0; i < 4; i++) m_vel[i] = 7'd0;
        m_act = 4'd0;
    endtask

    task automatic model_event(input bit on, input logic [6:0] note, input logic [6:0] vel);
        int s;
        s = -1;
        for (int i = 0; i < 4; i++)
            if (s < 0 && m_act[i] && m_note[i] == note) s = i;
        if (on && vel != 7'd0) begin
            for (int i = 0; i < 4; i++)
                if (s < 0 && !m_act[i]) s = i;
            if (s < 0) s = age[3];
            m_note[s] = note;
            m_vel[s]  = vel;
            m_act[s]  = 1'b1;
            for (int k = 0; k < age.size(); k++) begin
                if (age[k] == s) begin
                    age.delete(k);
                    break;
                end
            end
            age.push_front(s);
        end else if (s >= 0) begin
            m_vel[s] = 7'd0;
            m_act[s] = 1'b0;
        end
    endtask

    function automatic int get_num(input int i);
        case (i)
            0: return int'(NOTE_NUM_0);
            1: return int'(NOTE_NUM_1);
            2: return int'(NOTE_NUM_2);
            default: return int'(NOTE_NUM_3);
        endcase
    endfunction

    function automatic int get_vel(input int i);
        case (i)
            0: return int'(NOTE_VEL_0);
            1: return int'(NOTE_VEL_1);
            2: return int'(NOTE_VEL_2);
            default: return int'(NOTE_VEL_3);
        endcase
    endfunction

    task automatic check_model(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s note_num_%0d", tag, i), get_num(i), int'(m_note[i]));
            chk($sformatf("%s note_vel_%0d", tag, i), get_vel(i), int'(m_vel[i]));
        end
        chk($sformatf("%s voice_active", tag), int'(VOICE_ACTIVE), int'(m_act));
    endtask

    // Offer one event, wait for acceptance, then wait for the two further
    // CE edges after which the table update is visible. Updates the model.
    task automatic send(input bit on, input logic [6:0] note, input logic [6:0] vel, input bit rand_ce);
        bit acc;
        int n;
        @(negedge CLK);
        ALL_OFF = 1'b0;
        ev_if.EV_ON    = on;
        ev_if.EV_NOTE  = note;
        ev_if.EV_VEL   = vel;
        ev_if.EV_VALID = 1'b1;
        acc = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            CE = rand_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (ev_if.EV_READY) begin
                acc = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            ev_if.EV_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        n = 0;
        for (int cyc = 0; cyc < 200 && n < 2; cyc++) begin
            @(negedge CLK);
            ev_if.EV_VALID = 1'b0;
            ev_if.EV_ON    = 1'($urandom_range(0, 1));
            ev_if.EV_NOTE  = 7'($urandom_range(0, 127));
            ev_if.EV_VEL   = 7'($urandom_range(0, 127));
            CE = rand_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            chk("ready_low_busy", int'(ev_if.EV_READY), 0);
            @(posedge CLK);
            if (CE) n++;
        end
        if (n < 2) chk("busy_timeout", n, 2);
        model_event(on, note, vel);
        @(negedge CLK);
        CE = 1'b1;
        #1;
        chk("ready_after_event", int'(ev_if.EV_READY), 1);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        CE = 1'b1;
        ALL_OFF = 1'b0;
        ev_if.EV_VALID = 1'b0;
        #1;
        chk("ready_in_reset", int'(ev_if.EV_READY), 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        #1;
        check_model("reset");
        chk("ready_after_reset", int'(ev_if.EV_READY), 1);
    endtask

    typedef struct {
        bit         on;
        logic [6:0] note;
        logic [6:0] vel;
        logic [3:0] exp_act;
        int         slot;
        logic [6:0] exp_num;
        logic [6:0] exp_vel;
    } row_t;

    row_t rows [13];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rows[0]  = '{1'b1, 7'd60, 7'd100, 4'b0001, 0, 7'd60, 7'd100};
        rows[1]  = '{1'b1, 7'd60, 7'd80,  4'b0001, 0, 7'd60, 7'd80};
        rows[2]  = '{1'b1, 7'd64, 7'd80,  4'b0011, 1, 7'd64, 7'd80};
        rows[3]  = '{1'b1, 7'd67, 7'd80,  4'b0111, 2, 7'd67, 7'd80};
        rows[4]  = '{1'b1, 7'd72, 7'd80,  4'b1111, 3, 7'd72, 7'd80};
        rows[5]  = '{1'b1, 7'd76, 7'd90,  4'b1111, 0, 7'd76, 7'd90};
        rows[6]  = '{1'b1, 7'd64, 7'd50,  4'b1111, 1, 7'd64, 7'd50};
        rows[7]  = '{1'b0, 7'd64, 7'd0,   4'b1101, 1, 7'd64, 7'd0};
        rows[8]  = '{1'b1, 7'd64, 7'd0,   4'b1101, 1, 7'd64, 7'd0};
        rows[9]  = '{1'b0, 7'd99, 7'd0,   4'b1101, 1, 7'd64, 7'd0};
        rows[10] = '{1'b1, 7'd48, 7'd70,  4'b1111, 1, 7'd48, 7'd70};
        rows[11] = '{1'b1, 7'd50, 7'd60,  4'b1111, 2, 7'd50, 7'd60};
        rows[12] = '{1'b1, 7'd52, 7'd33,  4'b1111, 3, 7'd52, 7'd33};

        RST_N = 1'b0;
        CE = 1'b0;
        ALL_OFF = 1'b0;
        ev_if.EV_VALID = 1'b0;
        ev_if.EV_ON = 1'b0;
        ev_if.EV_NOTE = 7'd0;
        ev_if.EV_VEL = 7'd0;

        do_reset();

        // Directed table with fixed CE so the 2-cycle busy window is exact.
        for (int r = 0; r < 13; r++) begin
            send(rows[r].on, rows[r].note, rows[r].vel, 1'b0);
            chk($sformatf("row%0d voice_active", r), int'(VOICE_ACTIVE), int'(rows[r].exp_act));
            chk($sformatf("row%0d slot_num", r), get_num(rows[r].slot), int'(rows[r].exp_num));
            chk($sformatf("row%0d slot_vel", r), get_vel(rows[r].slot), int'(rows[r].exp_vel));
            check_model($sformatf("row%0d", r));
        end

        // CE low: event offered but never accepted, table holds.
        @(negedge CLK);
        CE = 1'b0;
        ev_if.EV_VALID = 1'b1;
        ev_if.EV_ON = 1'b1;
        ev_if.EV_NOTE = 7'd90;
        ev_if.EV_VEL = 7'd90;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("ready_ce_low", int'(ev_if.EV_READY), 0);
            @(negedge CLK);
        end
        ev_if.EV_VALID = 1'b0;
        check_model("ce_low_hold");

        // ALL_OFF together with a pending event: panic first, event waits.
        CE = 1'b1;
        ALL_OFF = 1'b1;
        ev_if.EV_VALID = 1'b1;
        ev_if.EV_ON = 1'b1;
        ev_if.EV_NOTE = 7'd70;
        ev_if.EV_VEL = 7'd40;
        #1;
        chk("ready_all_off", int'(ev_if.EV_READY), 0);
        @(negedge CLK);
        model_all_off();
        check_model("all_off");
        for (int k = 0; k < 2; k++) begin
            chk("ready_all_off_held", int'(ev_if.EV_READY), 0);
            @(negedge CLK);
        end
        check_model("all_off_held");
        send(1'b1, 7'd70, 7'd40, 1'b0);
        check_model("after_all_off_event");

        // Reset during MATCH: event lost, outputs drop immediately.
        @(negedge CLK);
        CE = 1'b1;
        ev_if.EV_VALID = 1'b1;
        ev_if.EV_ON = 1'b1;
        ev_if.EV_NOTE = 7'd33;
        ev_if.EV_VEL = 7'd99;
        #1;
        chk("ready_before_abort", int'(ev_if.EV_READY), 1);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        check_model("reset_in_match");
        chk("ready_reset_in_match", int'(ev_if.EV_READY), 0);
        @(negedge CLK);
        ev_if.EV_VALID = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        check_model("after_abort");

        // Randomized events with random CE against the model.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge CLK);
                CE = 1'b1;
                ALL_OFF = 1'b1;
                ev_if.EV_VALID = 1'($urandom_range(0, 1));
                @(negedge CLK);
                ALL_OFF = 1'b0;
                ev_if.EV_VALID = 1'b0;
                model_all_off();
                check_model("rand_all_off");
            end else begin
                send($urandom_range(0, 3) != 0,
                     7'(60 + $urandom_range(0, 7)),
                     ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
                     1'b1);
                check_model("rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
